exception_controller: RTL and testbench
=======================================

Name: exception_controller

Overview:
- Consumes the 2-bit exception code produced by the memory-stage exception detector.
- On a non-zero code, captures the faulting PC into the EPC and records the cause.
- Flushes the pipeline, fetches the 32-bit handler address from the data memory vector table as two 16-bit reads, and redirects fetch.
- Also services return-from-interrupt (RTI) by redirecting fetch to the saved EPC.

Parameters:
- ADDR_W, 32, PC / memory address width.
- DATA_W, 16, data memory word width; handler address = 2 words.
- VEC_INVALID, 32'h0000_0002, vector table address for cause 01 (address >= 0x0010_0000).
- VEC_PROTECTED, 32'h0000_0004, vector table address for cause 10 (protected region 0xFF01..0xFFFF).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_changeEPC  in  2  exception code from detector: 00 none, 01 invalid address, 10 protected address.
- i_mem_pc  in  ADDR_W  PC of the instruction currently in the memory stage.
- i_rti  in  1  RTI instruction in memory stage (single-cycle pulse).
- i_mem_ready  in  1  data memory read data valid this cycle.
- i_mem_rdata  in  DATA_W  data memory read data.
- o_mem_re  out  1  vector read request.
- o_mem_addr  out  ADDR_W  vector read address.
- o_flush  out  1  flush IF/ID/EX/MEM pipeline registers.
- o_stall  out  1  freeze PC and pipeline while handler fetch is in progress.
- o_pc_load  out  1  load o_pc_target into the PC this cycle.
- o_pc_target  out  ADDR_W  redirect target.
- o_epc  out  ADDR_W  exception PC register.
- o_cause  out  2  latched cause register.

Behaviour:
- Reset: state IDLE; all outputs 0, including o_epc, o_cause, o_pc_target and the internal handler-address register.
- Code resolution: bit0 set gives cause 01; else bit1 set gives cause 10. Code 11 resolves to 01.
- IDLE: when i_changeEPC != 00, at the next edge latch o_epc <= i_mem_pc and o_cause <= resolved cause, then go to FLUSH.
- IDLE RTI: when i_rti=1 and i_changeEPC=00, drive o_pc_load=1 and o_pc_target=o_epc combinationally in the same cycle; stay in IDLE.
- IDLE priority: an exception beats RTI in the same cycle; the RTI is dropped.
- FLUSH (1 cycle): o_flush=1, o_stall=1; go to READ_LO.
- READ_LO: o_mem_re=1, o_mem_addr=vector, o_stall=1.
  - On i_mem_ready, latch handler[15:0] <= i_mem_rdata and go to READ_HI.
  - Otherwise hold; there is no timeout.
- READ_HI: o_mem_re=1, o_mem_addr=vector+1, o_stall=1.
  - On i_mem_ready, latch handler[31:16] <= i_mem_rdata and go to REDIRECT.
- REDIRECT (1 cycle): o_pc_load=1, o_pc_target=handler, o_flush=1, o_stall=0; go to IDLE.
- Vector address: VEC_INVALID when o_cause=01, VEC_PROTECTED when o_cause=10. The +1 wraps modulo 2^ADDR_W.
- Minimum latency: detect in cycle T, FLUSH at T+1, READ_LO at T+2, READ_HI at T+3, REDIRECT at T+4. Each i_mem_ready wait cycle adds 1.
- Outside FLUSH..REDIRECT: i_changeEPC and i_rti are ignored; no nesting, o_epc/o_cause not overwritten.
- A new exception in the cycle IDLE is re-entered is accepted.
- o_epc and o_cause hold their values until the next accepted exception.
- Reset mid-sequence: immediate return to IDLE; all outputs 0; no partial redirect.

Decomposition:
- Shared package: cause encodings (CAUSE_NONE=00, CAUSE_INVALID=01, CAUSE_PROTECTED=10), FSM state enum (IDLE, FLUSH, READ_LO, READ_HI, REDIRECT), and the default vector addresses.
- Single module; the FSM and its registers are small, so no sub-module.

Test Plan:
- Reset then i_changeEPC=01, i_mem_pc=0x0000_0040, memory returns 0x1234 then 0x0000 with ready every cycle -> o_epc=0x40, o_cause=01; o_flush at T+1; o_mem_addr=2 then 3; o_pc_load=1 with o_pc_target=0x0000_1234 at T+4.
- i_changeEPC=10, memory ready delayed 3 cycles on each read -> o_mem_addr=4/5 held stable, o_stall=1 throughout, REDIRECT at T+10.
- Second i_changeEPC=01 pulse while in READ_LO -> ignored; o_epc unchanged; single REDIRECT.
- i_rti=1 in IDLE with o_epc=0x40 -> o_pc_load=1, o_pc_target=0x40 in the same cycle. i_rti and i_changeEPC=10 together -> exception taken, no RTI redirect.
- i_changeEPC=11 -> o_cause=01, vector read at VEC_INVALID.
- Assert i_rst_n=0 during READ_HI -> all outputs 0 asynchronously; after release, IDLE with o_pc_load never pulsed.

Source files
------------

// File: rtl/exception_controller_pkg.sv
// Shared encodings for the exception controller: cause codes, FSM states and
// the default vector-table addresses.
package exception_controller_pkg;

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_INVALID   = 2'b01;
    localparam logic [1:0] CAUSE_PROTECTED = 2'b10;

    localparam logic [31:0] VEC_INVALID_DEFAULT   = 32'h0000_0002;
    localparam logic [31:0] VEC_PROTECTED_DEFAULT = 32'h0000_0004;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        READ_LO,
        READ_HI,
        REDIRECT
    } state_t;

    // Invalid-address takes precedence, so a simultaneous 11 reports as 01.
    function automatic logic [1:0] resolve_cause(input logic [1:0] code);
        if (code[0])
            return CAUSE_INVALID;
        else if (code[1])
            return CAUSE_PROTECTED;
        else
            return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/exception_controller.sv
// Captures EPC/cause on a memory-stage exception, fetches the handler address
// from the vector table in two half-word reads, and redirects fetch; also serves RTI.
module exception_controller
    import exception_controller_pkg::*;
#(
    parameter int              ADDR_W        = 32,
    parameter int              DATA_W        = 16,
    parameter logic [ADDR_W-1:0] VEC_INVALID   = VEC_INVALID_DEFAULT,
    parameter logic [ADDR_W-1:0] VEC_PROTECTED = VEC_PROTECTED_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [1:0]        i_changeEPC,
    input  logic [ADDR_W-1:0] i_mem_pc,
    input  logic              i_rti,
    input  logic              i_mem_ready,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_mem_re,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_flush,
    output logic              o_stall,
    output logic              o_pc_load,
    output logic [ADDR_W-1:0] o_pc_target,
    output logic [ADDR_W-1:0] o_epc,
    output logic [1:0]        o_cause
);

    state_t            state_reg;
    logic [ADDR_W-1:0] epc_reg;
    logic [ADDR_W-1:0] handler_reg;
    logic [1:0]        cause_reg;
    logic [ADDR_W-1:0] vector;

    assign vector = (cause_reg == CAUSE_PROTECTED) ? VEC_PROTECTED : VEC_INVALID;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= IDLE;
            epc_reg     <= '0;
            handler_reg <= '0;
            cause_reg   <= CAUSE_NONE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_changeEPC != CAUSE_NONE) begin
                        epc_reg   <= i_mem_pc;
                        cause_reg <= resolve_cause(i_changeEPC);
                        state_reg <= FLUSH;
                    end
                end
                FLUSH: state_reg <= READ_LO;
                READ_LO: begin
                    if (i_mem_ready) begin
                        handler_reg[DATA_W-1:0] <= i_mem_rdata;
                        state_reg               <= READ_HI;
                    end
                end
                READ_HI: begin
                    if (i_mem_ready) begin
                        handler_reg[ADDR_W-1:DATA_W] <= i_mem_rdata;
                        state_reg                    <= REDIRECT;
                    end
                end
                REDIRECT: state_reg <= IDLE;
                default:  state_reg <= IDLE;
            endcase
        end
    end

    // Output decode; target/address are forced to zero whenever not in use.
    always_comb begin
        o_mem_re    = 1'b0;
        o_mem_addr  = '0;
        o_flush     = 1'b0;
        o_stall     = 1'b0;
        o_pc_load   = 1'b0;
        o_pc_target = '0;
        case (state_reg)
            IDLE: begin
                if (i_rti && (i_changeEPC == CAUSE_NONE)) begin
                    o_pc_load   = 1'b1;
                    o_pc_target = epc_reg;
                end
            end
            FLUSH: begin
                o_flush = 1'b1;
                o_stall = 1'b1;
            end
            READ_LO: begin
                o_mem_re   = 1'b1;
                o_mem_addr = vector;
                o_stall    = 1'b1;
            end
            READ_HI: begin
                o_mem_re   = 1'b1;
                o_mem_addr = vector + 1'b1;
                o_stall    = 1'b1;
            end
            REDIRECT: begin
                o_pc_load   = 1'b1;
                o_pc_target = handler_reg;
                o_flush     = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_epc   = epc_reg;
    assign o_cause = cause_reg;

endmodule

// File: tb/tb_exception_controller.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a transaction-level model.
module tb_exception_controller;

    logic        i_clk;
    logic        i_rst_n;
    logic [1:0]  i_changeEPC;
    logic [31:0] i_mem_pc;
    logic        i_rti;
    logic        i_mem_ready;
    logic [15:0] i_mem_rdata;
    logic        o_mem_re;
    logic [31:0] o_mem_addr;
    logic        o_flush;
    logic        o_stall;
    logic        o_pc_load;
    logic [31:0] o_pc_target;
    logic [31:0] o_epc;
    logic [1:0]  o_cause;

    int errors = 0;
    int checks = 0;

    exception_controller dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_changeEPC (i_changeEPC),
        .i_mem_pc    (i_mem_pc),
        .i_rti       (i_rti),
        .i_mem_ready (i_mem_ready),
        .i_mem_rdata (i_mem_rdata),
        .o_mem_re    (o_mem_re),
        .o_mem_addr  (o_mem_addr),
        .o_flush     (o_flush),
        .o_stall     (o_stall),
        .o_pc_load   (o_pc_load),
        .o_pc_target (o_pc_target),
        .o_epc       (o_epc),
        .o_cause     (o_cause)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h expected=%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: where in the handler sequence we are, counted in plain terms.
    bit          m_busy;        // an exception is being serviced
    bit          m_flushed;     // the flush cycle has happened
    int          m_words;       // handler half-words received (0..2)
    bit [31:0]   m_handler;
    bit [31:0]   m_epc;
    int          m_cause;

    always @(negedge i_clk) begin
        bit [31:0] e_addr, e_target;
        bit        e_re, e_flush, e_stall, e_load;
        e_re = 0; e_addr = 0; e_flush = 0; e_stall = 0; e_load = 0; e_target = 0;
        if (!i_rst_n) begin
            m_busy = 0; m_flushed = 0; m_words = 0; m_handler = 0; m_epc = 0; m_cause = 0;
        end else if (!m_busy) begin
            if (i_rti && i_changeEPC == 0) begin
                e_load = 1; e_target = m_epc;
            end
        end else if (!m_flushed) begin
            e_flush = 1; e_stall = 1;
        end else if (m_words < 2) begin
            e_re = 1; e_stall = 1;
            e_addr = ((m_cause == 2) ? 32'd4 : 32'd2) + 32'(m_words);
        end else begin
            e_load = 1; e_flush = 1; e_target = m_handler;
        end

        check("mem_re",    32'(o_mem_re),    32'(e_re));
        check("mem_addr",  o_mem_addr,       e_addr);
        check("flush",     32'(o_flush),     32'(e_flush));
        check("stall",     32'(o_stall),     32'(e_stall));
        check("pc_load",   32'(o_pc_load),   32'(e_load));
        check("pc_target", o_pc_target,      e_target);
        check("epc",       o_epc,            m_epc);
        check("cause",     32'(o_cause),     32'(m_cause));

        // advance model to what holds after the coming rising edge
        if (i_rst_n) begin
            if (!m_busy) begin
                if (i_changeEPC != 0) begin
                    m_busy = 1; m_flushed = 0; m_words = 0;
                    m_epc = i_mem_pc;
                    m_cause = (i_changeEPC == 2'b10) ? 2 : 1;
                end
            end else if (!m_flushed) begin
                m_flushed = 1;
            end else if (m_words < 2) begin
                if (i_mem_ready) begin
                    if (m_words == 0) m_handler[15:0] = i_mem_rdata;
                    else              m_handler[31:16] = i_mem_rdata;
                    m_words++;
                end
            end else begin
                m_busy = 0;
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int n;
        i_rst_n = 1; i_changeEPC = 0; i_mem_pc = 0; i_rti = 0; i_mem_ready = 0; i_mem_rdata = 0;
        #2 i_rst_n = 0;
        #1;
        check("reset_epc", o_epc, 32'h0);
        check("reset_load", 32'(o_pc_load), 32'h0);
        step(); step();
        i_rst_n = 1;
        step();
        $display("reset released");

        // Test 1: invalid address, ready every cycle
        i_changeEPC = 2'b01; i_mem_pc = 32'h40; i_mem_ready = 1; i_mem_rdata = 16'h1234;
        step();                                   // T+1
        i_changeEPC = 0;
        check("t1_flush", 32'(o_flush), 32'h1);
        step();                                   // T+2
        check("t1_addr_lo", o_mem_addr, 32'h2);
        step();                                   // T+3
        i_mem_rdata = 16'h0000;
        check("t1_addr_hi", o_mem_addr, 32'h3);
        step();                                   // T+4
        check("t1_load", 32'(o_pc_load), 32'h1);
        check("t1_target", o_pc_target, 32'h0000_1234);
        check("t1_epc", o_epc, 32'h40);
        check("t1_cause", 32'(o_cause), 32'h1);
        $display("txn1 invalid-address: target=%08h", o_pc_target);
        i_mem_ready = 0;
        step();

        // Test 4: RTI alone, then RTI together with an exception
        i_rti = 1;
        #1;
        check("rti_load", 32'(o_pc_load), 32'h1);
        check("rti_target", o_pc_target, 32'h40);
        $display("txn2 rti: target=%08h", o_pc_target);
        step();
        i_changeEPC = 2'b10; i_mem_pc = 32'h80;
        #1;
        check("rti_dropped", 32'(o_pc_load), 32'h0);
        step();
        i_rti = 0; i_changeEPC = 0;
        // Test 2: this exception runs with three wait cycles per read
        n = 1;
        while (!o_pc_load && n < 40) begin
            check("t2_addr_stable", o_mem_addr,
                  (n < 2) ? 32'h0 : (n < 6) ? 32'h4 : 32'h5);
            if (n < 6) check("t2_stall", 32'(o_stall), 32'h1);
            i_mem_ready = (n == 5 || n == 9);
            i_mem_rdata = (n == 5) ? 16'hBEEF : 16'h0001;
            // Test 3: stray exception while reading the vector is ignored
            i_changeEPC = (n == 3) ? 2'b01 : 2'b00;
            i_mem_pc = 32'h999;
            step();
            n++;
        end
        i_mem_ready = 0; i_changeEPC = 0;
        check("t2_latency", n, 10);
        check("t2_target", o_pc_target, 32'h0001_BEEF);
        check("t3_epc", o_epc, 32'h80);
        check("t3_cause", 32'(o_cause), 32'h2);
        $display("txn3 protected-address: redirect after %0d cycles target=%08h", n, o_pc_target);
        step();
        check("t3_single_redirect", 32'(o_pc_load), 32'h0);

        // Test 5: code 11 resolves to invalid
        i_changeEPC = 2'b11; i_mem_pc = 32'hC0;
        step(); i_changeEPC = 0;
        step();
        check("t5_cause", 32'(o_cause), 32'h1);
        check("t5_addr", o_mem_addr, 32'h2);
        $display("txn4 code11: cause=%0d addr=%08h", o_cause, o_mem_addr);
        // Test 6: reset while in READ_HI
        i_mem_ready = 1;
        step(); i_mem_ready = 0;
        check("t6_in_hi", o_mem_addr, 32'h3);
        #2 i_rst_n = 0;
        #1;
        check("t6_rst_re", 32'(o_mem_re), 32'h0);
        check("t6_rst_stall", 32'(o_stall), 32'h0);
        check("t6_rst_epc", o_epc, 32'h0);
        check("t6_rst_cause", 32'(o_cause), 32'h0);
        step();
        i_rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            check("t6_no_load", 32'(o_pc_load), 32'h0);
            step();
        end
        $display("txn5 reset mid-sequence: epc=%08h", o_epc);

        // Randomized run against the model
        for (int c = 0; c < 1500; c++) begin
            i_changeEPC = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            i_rti       = ($urandom_range(0, 5) == 0);
            i_mem_ready = ($urandom_range(0, 2) != 0);
            i_mem_rdata = 16'($urandom);
            i_mem_pc    = $urandom;
            step();
            if (o_pc_load)
                $display("rand cycle %0d: redirect target=%08h epc=%08h cause=%0d",
                         c, o_pc_target, o_epc, o_cause);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
